xvc_packet_fifo: RTL and testbench

Parametrised packet buffer between the XVC network-side command parser (writer) and the JTAG shift engine (reader). It holds up to SLOTS packets, each up to MAX_LEN words of DATA_W bits. Both sides address words inside a packet at random, and per-packet length travels with the data. Over the fixed single-depth buffer it adds full/empty status, abort, overrun detection and a registered read port.

---
 rtl/xvc_packet_fifo.sv | 162 ++++++++++++++++
 tb/tb_xvc_packet_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xvc_packet_fifo.sv
// xvc_packet_fifo
// Packet buffer between the XVC command parser (writer) and the JTAG shift engine (reader).
// Holds up to SLOTS packets of up to MAX_LEN words each. Both sides address words inside
// a packet at random; the packet length travels with the data.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_wr_en/i_wr_addr/i_wr_data  random-access write into the open slot
//   i_wr_commit                  close the open packet and queue it for the reader
//   i_wr_clear                   discard the open packet, clear overrun flag
//   o_wr_ready                   an open slot exists
//   o_wr_len                     length of the open packet
//   o_wr_overrun                 sticky: write/commit attempted while not ready
//   i_rd_next                    release the held packet and claim the next queued one
//   i_rd_addr/o_rd_data          random-access read of the held packet (1-cycle latency)
//   o_rd_valid, o_rd_len         reader holds a packet / its length
//   o_pkt_pending                committed packets not yet claimed
module xvc_packet_fifo #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SLOTS   = 4,
    parameter int unsigned MAX_LEN = 64,
    localparam int unsigned AW = $clog2(MAX_LEN),
    localparam int unsigned LW = $clog2(MAX_LEN + 1),
    localparam int unsigned CW = $clog2(SLOTS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_commit,
    input  logic              i_wr_clear,
    output logic              o_wr_ready,
    output logic [LW-1:0]     o_wr_len,
    output logic              o_wr_overrun,
    input  logic              i_rd_next,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [LW-1:0]     o_rd_len,
    output logic [CW-1:0]     o_pkt_pending
);

    localparam int unsigned PW = $clog2(SLOTS);

    typedef enum logic [0:0] {StIdle, StHold} rd_state_e;

    logic [DATA_W-1:0] r_mem [SLOTS*MAX_LEN];
    logic [LW-1:0]     r_slot_len [SLOTS];

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_wr_len;
    logic              r_overrun;
    logic [CW-1:0]     r_pending;
    rd_state_e         r_rd_state;
    logic [LW-1:0]     r_rd_len;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_rd_valid;
    logic [CW-1:0]     w_used;
    logic              w_wr_ready;
    logic              w_wr_fire;
    logic [LW-1:0]     w_addr_len;
    logic [LW-1:0]     w_eff_len;
    logic              w_commit;
    logic              w_claim;
    logic              w_release;
    logic [PW-1:0]     w_rd_ptr_nxt;

    assign w_rd_valid = (r_rd_state == StHold);
    assign w_used     = r_pending + CW'(w_rd_valid);
    assign w_wr_ready = (w_used < CW'(SLOTS));

    // Clear wins over a same-cycle write or commit.
    assign w_wr_fire  = i_wr_en & w_wr_ready & ~i_wr_clear;
    assign w_addr_len = LW'(i_wr_addr) + LW'(1);
    // Effective length folds in a same-cycle write so write+commit closes the full packet.
    assign w_eff_len  = (w_wr_fire && (w_addr_len > r_wr_len)) ? w_addr_len : r_wr_len;
    assign w_commit   = i_wr_commit & w_wr_ready & ~i_wr_clear & (w_eff_len != '0);

    // Claim only counts packets committed before this edge, so there is no bypass.
    assign w_claim      = i_rd_next & (r_pending != '0);
    assign w_release    = i_rd_next & w_rd_valid;
    assign w_rd_ptr_nxt = w_release ? (r_rd_ptr + PW'(1)) : r_rd_ptr;

    // Packet storage is not reset; contents are only visible after commit and claim.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem[{r_wr_ptr, i_wr_addr}] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_len   <= '0;
            r_overrun  <= 1'b0;
            r_pending  <= '0;
            r_rd_state <= StIdle;
            r_rd_len   <= '0;
            r_rd_data  <= '0;
            for (int i = 0; i < int'(SLOTS); i++) begin
                r_slot_len[i] <= '0;
            end
        end else begin
            // Write side
            if (i_wr_clear) begin
                r_wr_len  <= '0;
                r_overrun <= 1'b0;
            end else begin
                if ((i_wr_en | i_wr_commit) & ~w_wr_ready) begin
                    r_overrun <= 1'b1;
                end
                if (w_commit) begin
                    r_slot_len[r_wr_ptr] <= w_eff_len;
                    r_wr_ptr             <= r_wr_ptr + PW'(1);
                    r_wr_len             <= '0;
                end else begin
                    r_wr_len <= w_eff_len;
                end
            end

            r_pending <= r_pending + CW'(w_commit) - CW'(w_claim);

            // Read FSM; a release+claim moves straight to the next slot.
            unique case (r_rd_state)
                StIdle: begin
                    if (w_claim) begin
                        r_rd_state <= StHold;
                        r_rd_len   <= r_slot_len[r_rd_ptr];
                    end
                end
                StHold: begin
                    if (i_rd_next) begin
                        r_rd_ptr <= w_rd_ptr_nxt;
                        if (w_claim) begin
                            r_rd_len <= r_slot_len[w_rd_ptr_nxt];
                        end else begin
                            r_rd_state <= StIdle;
                            r_rd_len   <= '0;
                        end
                    end
                end
            endcase

            // Reading through the next pointer makes the word after a switch come from
            // the newly claimed slot.
            r_rd_data <= r_mem[{w_rd_ptr_nxt, i_rd_addr}];
        end
    end

    assign o_wr_ready    = w_wr_ready;
    assign o_wr_len      = r_wr_len;
    assign o_wr_overrun  = r_overrun;
    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = w_rd_valid;
    assign o_rd_len      = r_rd_len;
    assign o_pkt_pending = r_pending;

endmodule

// File: tb/tb_xvc_packet_fifo.sv
// Self-checking bench for xvc_packet_fifo (default parameters: 8-bit words, 4 slots, 64 words).
// Status outputs are checked directly after each step; read data goes through a scoreboard
// queue that a separate monitor drains on the falling edge.
module tb_xvc_packet_fifo;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned SLOTS   = 4;
    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned CW = $clog2(SLOTS + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_commit = 1'b0;
    logic              wr_clear = 1'b0;
    logic              wr_ready;
    logic [LW-1:0]     wr_len;
    logic              wr_overrun;
    logic              rd_next = 1'b0;
    logic [AW-1:0]     rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [LW-1:0]     rd_len;
    logic [CW-1:0]     pkt_pending;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic              rd_strobe = 1'b0;

    xvc_packet_fifo #(
        .DATA_W (DATA_W),
        .SLOTS  (SLOTS),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_wr_commit  (wr_commit),
        .i_wr_clear   (wr_clear),
        .o_wr_ready   (wr_ready),
        .o_wr_len     (wr_len),
        .o_wr_overrun (wr_overrun),
        .i_rd_next    (rd_next),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid),
        .o_rd_len     (rd_len),
        .o_pkt_pending(pkt_pending)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: compares read data against the oldest expected word.
    always @(negedge clk) begin
        if (rd_strobe) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_data: got %0h, required none (scoreboard empty)", rd_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e || rd_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL rd_data: got %0h (valid %0b), required %0h (valid 1)",
                             rd_data, rd_valid, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = DATA_W'(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        step();
        wr_commit = 1'b0;
    endtask

    task automatic rdnext();
        rd_next = 1'b1;
        step();
        rd_next = 1'b0;
    endtask

    // Address held over two edges so the word is settled regardless of pipeline alignment.
    task automatic rdchk(input int a, input int e);
        rd_addr = AW'(a);
        step();
        step();
        exp_q.push_back(DATA_W'(e));
        rd_strobe = 1'b1;
        @(negedge clk);
        #1;
        rd_strobe = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " wr_ready"}, int'(wr_ready), 1);
        chk({tag, " wr_len"}, int'(wr_len), 0);
        chk({tag, " wr_overrun"}, int'(wr_overrun), 0);
        chk({tag, " rd_valid"}, int'(rd_valid), 0);
        chk({tag, " rd_len"}, int'(rd_len), 0);
        chk({tag, " rd_data"}, int'(rd_data), 0);
        chk({tag, " pkt_pending"}, int'(pkt_pending), 0);
    endtask

    initial begin
        // Reset
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        // Base traffic: two packets
        for (int i = 0; i < 8; i++) wr(i, 100 + i);
        chk("base wr_len pre-commit", int'(wr_len), 8);
        commit();
        chk("base wr_len post-commit", int'(wr_len), 0);
        chk("base pending 1", int'(pkt_pending), 1);
        for (int i = 0; i < 4; i++) wr(i, 200 + i);
        commit();
        chk("base pending 2", int'(pkt_pending), 2);
        rdnext();
        chk("base rd_valid", int'(rd_valid), 1);
        chk("base rd_len 8", int'(rd_len), 8);
        chk("base pending after claim", int'(pkt_pending), 1);
        for (int i = 0; i < 8; i++) rdchk(i, 100 + i);
        rdnext();
        chk("base rd_len 4", int'(rd_len), 4);
        chk("base pending 0", int'(pkt_pending), 0);
        for (int i = 0; i < 4; i++) rdchk(i, 200 + i);
        rdnext();
        chk("base rd_valid idle", int'(rd_valid), 0);
        chk("base rd_len idle", int'(rd_len), 0);

        // Full and overrun
        for (int i = 0; i < 4; i++) begin
            wr(0, 10 + i);
            commit();
        end
        chk("full wr_ready", int'(wr_ready), 0);
        chk("full pending", int'(pkt_pending), 4);
        wr(0, 99);
        chk("full overrun", int'(wr_overrun), 1);
        chk("full dropped wr_len", int'(wr_len), 0);
        rdnext();
        chk("full claim pending", int'(pkt_pending), 3);
        chk("full still not ready", int'(wr_ready), 0);
        rdnext();
        chk("full ready after release", int'(wr_ready), 1);
        chk("full release+claim pending", int'(pkt_pending), 2);
        rdchk(0, 11);
        wr_clear = 1'b1;
        step();
        wr_clear = 1'b0;
        chk("clear overrun", int'(wr_overrun), 0);
        rdnext();
        rdchk(0, 12);
        rdnext();
        rdchk(0, 13);
        rdnext();
        chk("full drained rd_valid", int'(rd_valid), 0);
        chk("full drained pending", int'(pkt_pending), 0);

        // Sparse and simultaneous writes
        wr(5, 8'h55);
        chk("sparse wr_len", int'(wr_len), 6);
        wr_commit = 1'b1;
        wr(9, 8'hAA);
        wr_commit = 1'b0;
        chk("simul pending", int'(pkt_pending), 1);
        chk("simul wr_len", int'(wr_len), 0);
        rdnext();
        chk("simul rd_len", int'(rd_len), 10);
        rdchk(9, 8'hAA);
        rdchk(5, 8'h55);
        rdnext();

        // Abort
        for (int i = 0; i < 3; i++) wr(i, 50 + i);
        wr_clear = 1'b1; wr_commit = 1'b1;
        step();
        wr_clear = 1'b0; wr_commit = 1'b0;
        chk("abort pending", int'(pkt_pending), 0);
        chk("abort wr_len", int'(wr_len), 0);
        commit();
        chk("empty commit pending", int'(pkt_pending), 0);
        chk("empty commit overrun", int'(wr_overrun), 0);
        rdnext();
        chk("idle rd_next rd_valid", int'(rd_valid), 0);

        // Wrap-around with interleaved reader
        for (int p = 1; p <= 10; p++) begin
            for (int i = 0; i < p; i++) wr(i, p);
            commit();
            rdnext();
            chk($sformatf("wrap rd_len %0d", p), int'(rd_len), p);
            for (int i = 0; i < p; i++) rdchk(i, p);
        end
        rdnext();
        chk("wrap end rd_valid", int'(rd_valid), 0);
        chk("wrap end wr_ready", int'(wr_ready), 1);

        // Reset mid-operation: three packets queued, one claimed, one open
        for (int k = 0; k < 3; k++) begin
            wr(0, 30 + k);
            wr(1, 40 + k);
            commit();
        end
        rdnext();
        wr(0, 77);
        wr_en = 1'b1;
        wr_addr = '0;
        chk("pre-reset pending", int'(pkt_pending), 2);
        rst = 1'b1;
        #2;
        wr_en = 1'b0;
        chk_reset_vals("mid-reset");
        rst = 1'b0;
        #1;
        wr(0, 8'h5A);
        wr(1, 8'h5B);
        commit();
        chk("post-reset pending", int'(pkt_pending), 1);
        rdnext();
        chk("post-reset rd_len", int'(rd_len), 2);
        rdchk(0, 8'h5A);
        rdchk(1, 8'h5B);

        step();
        chk("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

endmodule
